mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port 256×32 synchronous program/data memory between the processor's instruction-fetch port and its load/store port. It accepts at most one request per cycle, drives the memory, and routes the 1-cycle-latency read data back to the requester that issued it. Tie-breaking between the two ports is fixed priority or round-robin, selected at compile time. It sits between `Processor` and the memory array, replacing the processor's direct `mem_rdata` hookup.

## Interface
Parameters:
- `DEPTH`, 256: memory depth in 32-bit words; must be a power of two.
- `ADDR_W`, 8: word-address width, equal to log2(`DEPTH`).

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: synchronous, active-low reset.
- `if_req` in 1: fetch read request; held with `if_addr` until `if_gnt`.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: fetch read data valid.
- `if_rdata` out 32: fetch read data.
- `d_req` in 1: data request; held with its address/data/mask until `d_gnt`.
- `d_we` in 1: 1 selects a write, 0 selects a read.
- `d_wmask` in 4: byte write enables.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: write data.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: data read data valid. Reads only.
- `d_rdata` out 32: data read data.
- `d_err` out 1: the accepted access was out of range. Pulses with `d_rvalid` for reads, and the cycle after `d_gnt` for writes.
- `mem_en` out 1: memory access enable.
- `mem_wmask` out 4: memory byte write enables.
- `mem_addr` out `ADDR_W`: memory word address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, registered by the memory and valid the cycle after `mem_en`.

## Operation
Grant rules:
- Grant is combinational in the request cycle. At most one of `if_gnt`/`d_gnt` is high per cycle.
- A single requester is granted immediately.
- When both request, the tie-break decides (see Configuration).

Memory drive:
- `mem_addr` = granted address bits [`ADDR_W`+1:2]. Address bits [1:0] are ignored; there is no misalignment handling.
- `mem_wmask` = `d_wmask` when the data write is granted and in range, otherwise 0.

Out-of-range accesses:
- An access is out of range when the byte address is ≥ `DEPTH`×4.
- The request is still granted, but `mem_en` stays 0 and nothing is written.
- A read returns rdata 0. `d_err` pulses for data-port accesses; the fetch port has no error flag and returns 0.

Response tracking:
- An owner register (NONE/IF/D) records which port issued the read in flight.
- The next cycle, the owner's rvalid is asserted and `mem_rdata` (or 0 if out of range) is steered to it. The other port's rdata is held at its last value.
- Writes set owner to NONE.

## Timing
- Reset values: `if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `d_err`, `mem_en` are 0; `mem_wmask` is 0; `if_rdata`, `d_rdata` are 0; owner is NONE; last-grant register is IF.
- Read latency: grant in cycle N, rvalid and rdata in cycle N+1.
- Throughput: one access per cycle. Back-to-back grants to the same or alternating ports are allowed.
- Write: committed at the clock edge ending the grant cycle. A read of the same address granted in the next cycle returns the new data.
- Reset is asserted while a read is in flight: the response is dropped and no rvalid follows. While `resetn`=0, all grants and `mem_en` are forced to 0.
- A request is dropped (req deasserted) before its grant: nothing is issued. Dropping a request after its grant is legal.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On a tie, grant the port not in the last-grant register. The last-grant register updates on every grant. Consequence: after reset, the first tie goes to the data port.
- `MEM_ARB_RR_EN` undefined: fixed priority. The data port always wins ties and the last-grant register is not built. The fetch port can stall indefinitely under continuous `d_req`.

## Structure
- Package `mem_arb_pkg` holds:
  - the owner enum (`OWN_NONE`, `OWN_IF`, `OWN_D`);
  - the port-index constants (`PORT_IF`=0, `PORT_D`=1);
  - a `word_addr` helper.
- Sub-module `mem_arb_rr2` is the 2-input grant logic with the optional last-grant register, instantiated once.
- The top level holds the address decode, the memory muxing and the response pipeline.

## Test plan
- Fetch only, `if_addr`=0x10, MEM[4]=0x003100B3: `if_gnt` in cycle N; in cycle N+1, `if_rvalid`=1 and `if_rdata`=0x003100B3.
- Data write, `d_addr`=0x20, `d_wdata`=0xDEADBEEF, `d_wmask`=0b0011, old MEM[8]=0x11223344: read-back in N+2 returns 0x1122BEEF; `d_rvalid` is not asserted for the write.
- Both request for 4 cycles:
  - with `MEM_ARB_RR_EN`: grants are D, IF, D, IF;
  - without it: D, D, D, D, and `if_gnt` stays 0.
- `d_addr`=0x400 read: `d_gnt`=1 and `mem_en`=0; the next cycle, `d_rvalid`=1, `d_err`=1 and `d_rdata`=0.
- Fetch granted in cycle N and `resetn`=0 in cycle N+1: `if_rvalid` stays 0. After release, the first tie grants the data port.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch / load-store memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int PORT_IF = 0;
  localparam int PORT_D  = 1;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-input combinational grant; MEM_ARB_RR_EN selects round-robin tie-break,
// otherwise the data port wins every tie. Grants are forced low during reset.
module mem_arb_rr2 import mem_arb_pkg::*; (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic tie_to_d;

`ifdef MEM_ARB_RR_EN
  logic last_q;
  logic last_d;

  // A tie goes to whichever port did not win most recently.
  assign tie_to_d = (last_q == 1'(PORT_IF));

  always_comb begin
    last_d = last_q;
    if (gnt_o[PORT_D])
      last_d = 1'(PORT_D);
    else if (gnt_o[PORT_IF])
      last_d = 1'(PORT_IF);
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i)
      last_q <= 1'(PORT_IF);
    else
      last_q <= last_d;
  end
`else
  logic unused_clk;
  assign unused_clk = clk_i;
  assign tie_to_d   = 1'b1;
`endif

  always_comb begin
    gnt_o = 2'b00;
    if (resetn_i) begin
      if (req_i[PORT_IF] && req_i[PORT_D]) begin
        gnt_o[PORT_D]  = tie_to_d;
        gnt_o[PORT_IF] = !tie_to_d;
      end else begin
        gnt_o = req_i;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 1-cycle-latency memory between fetch and load/store ports; one access per cycle.
// Tie-break is round-robin when MEM_ARB_RR_EN is defined, data-port priority otherwise.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic [3:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [31:0] sel_addr;
  logic [31:0] sel_word;
  logic        in_range;

  owner_e      owner_q, owner_d;
  logic        oor_q;
  logic        d_err_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic [31:0] rsp_data;

  assign req[PORT_IF] = if_req;
  assign req[PORT_D]  = d_req;

  mem_arb_rr2 u_rr2 (
    .clk_i    (clk),
    .resetn_i (resetn),
    .req_i    (req),
    .gnt_o    (gnt)
  );

  assign if_gnt = gnt[PORT_IF];
  assign d_gnt  = gnt[PORT_D];

  assign sel_addr = d_gnt ? d_addr : if_addr;
  assign sel_word = word_addr(sel_addr);
  assign in_range = (sel_addr < 32'(DEPTH * 4));

  // Out-of-range accesses are still granted but never reach the array.
  assign mem_en    = (if_gnt || d_gnt) && in_range;
  assign mem_addr  = sel_word[ADDR_W-1:0];
  assign mem_wdata = d_wdata;
  assign mem_wmask = (d_gnt && d_we && in_range) ? d_wmask : 4'b0000;

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt)
      owner_d = OWN_IF;
    else if (d_gnt && !d_we)
      owner_d = OWN_D;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner_q    <= OWN_NONE;
      oor_q      <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      owner_q    <= owner_d;
      oor_q      <= !in_range;
      d_err_q    <= d_gnt && !in_range;
      if_rdata_q <= if_rdata;
      d_rdata_q  <= d_rdata;
    end
  end

  // Gating with resetn drops a response whose cycle coincides with reset.
  assign rsp_data  = oor_q ? 32'h0 : mem_rdata;
  assign if_rvalid = resetn && (owner_q == OWN_IF);
  assign d_rvalid  = resetn && (owner_q == OWN_D);
  assign d_err     = resetn && d_err_q;
  assign if_rdata  = if_rvalid ? rsp_data : if_rdata_q;
  assign d_rdata   = d_rvalid  ? rsp_data : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a cycle-level reference model and hand-pinned expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_wmask;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_wmask;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory array the arbiter drives: registered read, byte-masked write.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rules applied per cycle, state is just the pending response.
  logic        m_pend_if  = 1'b0;
  logic        m_pend_d   = 1'b0;
  logic        m_pend_err = 1'b0;
  logic [31:0] m_pend_dat = 32'h0;
  logic [31:0] m_hold_if  = 32'h0;
  logic [31:0] m_hold_d   = 32'h0;
  logic        m_hold_ok  = 1'b0;
  logic        m_last_d   = 1'b0;

  always @(negedge clk) begin
    logic        e_if, e_d, e_en, e_wr, rng;
    logic [31:0] a, e_ird, e_drd;
    logic [3:0]  e_wm;

    e_ird = (resetn && m_pend_if) ? m_pend_dat : m_hold_if;
    e_drd = (resetn && m_pend_d)  ? m_pend_dat : m_hold_d;
    check("if_rvalid", {31'b0, if_rvalid}, {31'b0, resetn & m_pend_if});
    check("d_rvalid",  {31'b0, d_rvalid},  {31'b0, resetn & m_pend_d});
    check("d_err",     {31'b0, d_err},     {31'b0, resetn & m_pend_err});
    if (m_hold_ok) begin
      check("if_rdata", if_rdata, e_ird);
      check("d_rdata",  d_rdata,  e_drd);
    end

    e_if = 1'b0;
    e_d  = 1'b0;
    if (resetn) begin
      if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
        e_d = !m_last_d;
`else
        e_d = 1'b1;
`endif
        e_if = !e_d;
      end else begin
        e_if = if_req;
        e_d  = d_req;
      end
    end
    a    = e_d ? d_addr : if_addr;
    rng  = (a < 32'h400);
    e_en = (e_if || e_d) && rng;
    e_wr = e_d && d_we && rng;
    e_wm = e_wr ? d_wmask : 4'b0;

    check("if_gnt",    {31'b0, if_gnt}, {31'b0, e_if});
    check("d_gnt",     {31'b0, d_gnt},  {31'b0, e_d});
    check("mem_en",    {31'b0, mem_en}, {31'b0, e_en});
    check("mem_wmask", {28'b0, mem_wmask}, {28'b0, e_wm});
    if (e_en) check("mem_addr", {24'b0, mem_addr}, {24'b0, a[9:2]});
    if (e_wr) check("mem_wdata", mem_wdata, d_wdata);

    if (!resetn) begin
      m_pend_if  = 1'b0;
      m_pend_d   = 1'b0;
      m_pend_err = 1'b0;
      m_hold_if  = 32'h0;
      m_hold_d   = 32'h0;
      m_hold_ok  = 1'b1;
      m_last_d   = 1'b0;
    end else begin
      m_hold_if  = e_ird;
      m_hold_d   = e_drd;
      m_pend_if  = e_if;
      m_pend_d   = e_d && !d_we;
      m_pend_err = e_d && !rng;
      m_pend_dat = rng ? ref_mem[a[9:2]] : 32'h0;
      if (e_wr)
        for (int b = 0; b < 4; b++)
          if (d_wmask[b]) ref_mem[a[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
      if (e_if || e_d) m_last_d = e_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] tie_d_pat;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 + 32'(i * 3);
      ref_mem[i] = 32'hA500_0000 + 32'(i * 3);
    end
    mem[4] = 32'h003100B3;  ref_mem[4] = 32'h003100B3;
    mem[8] = 32'h11223344;  ref_mem[8] = 32'h11223344;
`ifdef MEM_ARB_RR_EN
    tie_d_pat = 4'b0101;
`else
    tie_d_pat = 4'b1111;
`endif

    resetn = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_wmask = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'h0);
    tick();
    resetn = 1'b1;
    tick();

    // Fetch only
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("fetch_gnt", {31'b0, if_gnt}, 32'd1);
    check("fetch_mem_addr", {24'b0, mem_addr}, 32'd4);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("fetch_rvalid", {31'b0, if_rvalid}, 32'd1);
    check("fetch_rdata", if_rdata, 32'h003100B3);
    tick();

    // Masked write followed by read-back of the same word
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011;
    @(negedge clk);
    check("wr_gnt", {31'b0, d_gnt}, 32'd1);
    check("wr_mem_wmask", {28'b0, mem_wmask}, 32'h3);
    tick();
    d_we = 1'b0;
    @(negedge clk);
    check("wr_no_rvalid", {31'b0, d_rvalid}, 32'd0);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    check("rb_rvalid", {31'b0, d_rvalid}, 32'd1);
    check("rb_rdata", d_rdata, 32'h1122BEEF);
    tick();

    // Tie-break: a fetch-only grant first so the last winner is the fetch port
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tie_d_gnt",  {31'b0, d_gnt},  {31'b0, tie_d_pat[i]});
      check("tie_if_gnt", {31'b0, if_gnt}, {31'b0, !tie_d_pat[i]});
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // Out-of-range read, then out-of-range write, then out-of-range fetch
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    @(negedge clk);
    check("oor_gnt", {31'b0, d_gnt}, 32'd1);
    check("oor_mem_en", {31'b0, mem_en}, 32'd0);
    tick();
    d_we = 1'b1; d_addr = 32'h404; d_wmask = 4'hF; d_wdata = 32'h12345678;
    @(negedge clk);
    check("oor_rvalid", {31'b0, d_rvalid}, 32'd1);
    check("oor_err", {31'b0, d_err}, 32'd1);
    check("oor_rdata", d_rdata, 32'h0);
    check("oorw_wmask", {28'b0, mem_wmask}, 32'h0);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    check("oorw_err", {31'b0, d_err}, 32'd1);
    check("oorw_no_rvalid", {31'b0, d_rvalid}, 32'd0);
    tick();
    if_req = 1'b1; if_addr = 32'h1000;
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("oorf_rvalid", {31'b0, if_rvalid}, 32'd1);
    check("oorf_rdata", if_rdata, 32'h0);
    tick();

    // Reset while a fetch is in flight
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("rif_gnt", {31'b0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0; resetn = 1'b0;
    @(negedge clk);
    check("rif_dropped", {31'b0, if_rvalid}, 32'd0);
    tick();
    tick();
    resetn = 1'b1; if_req = 1'b1; if_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    @(negedge clk);
    check("post_rst_tie_d", {31'b0, d_gnt}, 32'd1);
    check("post_rst_tie_if", {31'b0, if_gnt}, 32'd0);
    tick();
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // Mixed traffic with some requests dropped before grant
    for (int i = 0; i < 80; i++) begin
      if_req  = 1'($urandom_range(0, 1));
      if_addr = 32'($urandom_range(0, 300)) << 2;
      d_req   = 1'($urandom_range(0, 1));
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = 32'($urandom_range(0, 300)) << 2;
      d_wmask = 4'($urandom_range(0, 15));
      d_wdata = $urandom;
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
